// File: rtl/systolic_skew_feeder_pkg.sv
// Shared definitions for the systolic skew feeder and the array top.
package systolic_skew_feeder_pkg;

  localparam int DEF_ARR_SIZE      = 4;
  localparam int DEF_HORIZONTAL_BW = 16;
  localparam int DEF_DRAIN_CYCLES  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DRAIN  = 2'd3
  } feeder_state_e;

  // Bit offset of lane 'lane' in a packed vector of 'bw'-bit elements.
  function automatic int lane_lsb(input int lane, input int bw);
    return lane * bw;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Beat-level valid/ready stream carrying one A row and one B column per beat.
interface systolic_skew_feeder_if
  import systolic_skew_feeder_pkg::*;
#(
  parameter int ARR_SIZE      = DEF_ARR_SIZE,
  parameter int HORIZONTAL_BW = DEF_HORIZONTAL_BW
) ();

  logic                              s_valid;
  logic                              s_ready;
  logic                              s_last;
  logic [HORIZONTAL_BW*ARR_SIZE-1:0] s_row;
  logic [HORIZONTAL_BW*ARR_SIZE-1:0] s_col;

  modport master (output s_valid, output s_last, output s_row, output s_col, input s_ready);
  modport slave  (input s_valid, input s_last, input s_row, input s_col, output s_ready);

endinterface

// File: rtl/systolic_skew_feeder_skew_lane_delay.sv
// Fixed-depth shift register for one lane of the diagonal skew.
module skew_lane_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_reg [DEPTH];

  // Shift the chain one stage per enabled clock; reset clears every stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) stage_reg[k] <= '0;
    end else if (shift_en) begin
      stage_reg[0] <= din;
      for (int k = 1; k < DEPTH; k++) stage_reg[k] <= stage_reg[k-1];
    end
  end

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skews A rows / B columns into a diagonal wavefront, then flushes and drains.
// Assumes ARR_SIZE >= 2 so the flush phase is at least one cycle long.
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
#(
  parameter int ARR_SIZE      = DEF_ARR_SIZE,
  parameter int HORIZONTAL_BW = DEF_HORIZONTAL_BW,
  parameter int DRAIN_CYCLES  = DEF_DRAIN_CYCLES
) (
  input  logic                              clk,
  input  logic                              rst,
  systolic_skew_feeder_if.slave             s,
  output logic [HORIZONTAL_BW*ARR_SIZE-1:0] o_horizontal,
  output logic [HORIZONTAL_BW*ARR_SIZE-1:0] o_vertical,
  output logic                              o_busy,
  output logic                              o_done
);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] STREAM = ST_STREAM;
  localparam logic [1:0] FLUSH  = ST_FLUSH;
  localparam logic [1:0] DRAIN  = ST_DRAIN;

  localparam int CNT_MAX = (ARR_SIZE > DRAIN_CYCLES) ? ARR_SIZE : DRAIN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int VW      = HORIZONTAL_BW * ARR_SIZE;

  // Last counter value of each phase: flush lasts ARR_SIZE-1 cycles, drain DRAIN_CYCLES.
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(ARR_SIZE - 2);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             done_reg, done_next;
  logic             hs;
  logic [VW-1:0]    row_in, col_in;

  // Ready depends only on state (and reset), never on s_valid.
  assign s.s_ready = rst && ((state_reg == IDLE) || (state_reg == STREAM));
  assign hs        = s.s_valid && s.s_ready;

  // Cycles without an accepted beat inject matched zero bubbles on A and B.
  assign row_in = hs ? s.s_row : '0;
  assign col_in = hs ? s.s_col : '0;

  // Pass sequencing: stream beats, flush the skew, drain the array, flag done.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE, STREAM: begin
        if (hs) begin
          state_next = s.s_last ? FLUSH : STREAM;
          cnt_next   = '0;
        end
      end
      FLUSH: begin
        if (cnt_reg == FLUSH_LAST) begin
          cnt_next = '0;
          if (DRAIN_CYCLES == 0) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = DRAIN;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (cnt_reg == DRAIN_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State, counter and done pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
    end
  end

  assign o_busy = (state_reg != IDLE);
  assign o_done = done_reg;

  // Lane i gets i+1 stages. The chains run every cycle, so IDLE keeps them zero.
  for (genvar gi = 0; gi < ARR_SIZE; gi++) begin : g_lane
    skew_lane_delay #(.DEPTH(gi + 1), .WIDTH(HORIZONTAL_BW)) u_row (
      .clk      (clk),
      .rst      (rst),
      .shift_en (1'b1),
      .din      (row_in[lane_lsb(gi, HORIZONTAL_BW) +: HORIZONTAL_BW]),
      .dout     (o_horizontal[lane_lsb(gi, HORIZONTAL_BW) +: HORIZONTAL_BW])
    );
    skew_lane_delay #(.DEPTH(gi + 1), .WIDTH(HORIZONTAL_BW)) u_col (
      .clk      (clk),
      .rst      (rst),
      .shift_en (1'b1),
      .din      (col_in[lane_lsb(gi, HORIZONTAL_BW) +: HORIZONTAL_BW]),
      .dout     (o_vertical[lane_lsb(gi, HORIZONTAL_BW) +: HORIZONTAL_BW])
    );
  end

endmodule
